// File: rtl/pt_feedback_pkg.sv
// ---------------------------------------------------------------------------
// pt_feedback_pkg
// Shared definitions for the feedback-chain fade/split blocks.
//   fade_state_e : per-channel fade FSM encoding
//   N_CH         : number of output channels of the splitter
// ---------------------------------------------------------------------------
package pt_feedback_pkg;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } fade_state_e;

    localparam int N_CH = 8;

endpackage : pt_feedback_pkg

// File: rtl/fade_gate_channel.sv
// ---------------------------------------------------------------------------
// fade_gate_channel
// One splitter output channel: a fade FSM with a linear gain register and a
// registered multiply/shift output stage.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   sat_i          : saturated input sample (OUTPUT_WIDTH, signed)
//   sel_i          : channel on request
//   tick_i         : gain step strobe from the shared prescaler
//   data_o         : faded output sample (registered)
//   active_o       : FSM not in OFF
//   ramping_o      : FSM in RAMP_UP or RAMP_DOWN
// ---------------------------------------------------------------------------
module fade_gate_channel
    import pt_feedback_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 14,
    parameter int FADE_BITS    = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic signed [OUTPUT_WIDTH-1:0] sat_i,
    input  logic                           sel_i,
    input  logic                           tick_i,
    output logic signed [OUTPUT_WIDTH-1:0] data_o,
    output logic                           active_o,
    output logic                           ramping_o
);

    localparam int GW = FADE_BITS + 1;
    localparam int PW = OUTPUT_WIDTH + FADE_BITS + 1;
    localparam logic [GW-1:0] GAIN_MAX = {1'b1, {FADE_BITS{1'b0}}};

    fade_state_e state_q, state_d;
    logic [GW-1:0] gain_q, gain_d;
    logic signed [OUTPUT_WIDTH-1:0] data_q, data_d;
    logic signed [PW-1:0] prod;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_OFF;
            gain_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            data_q  <= data_d;
        end
    end

    // Direction is resolved from the select first, then a tick steps the
    // gain in that (possibly new) direction in the same cycle. Reaching an
    // end stop moves the FSM to the matching steady state, which also covers
    // a reversal that lands exactly on an end stop.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        case (state_q)
            ST_OFF:       if (sel_i)  state_d = ST_RAMP_UP;
            ST_RAMP_UP:   if (!sel_i) state_d = ST_RAMP_DOWN;
            ST_ON:        if (!sel_i) state_d = ST_RAMP_DOWN;
            ST_RAMP_DOWN: if (sel_i)  state_d = ST_RAMP_UP;
            default:                  state_d = ST_OFF;
        endcase
        if (state_d == ST_RAMP_UP) begin
            if (tick_i && (gain_q != GAIN_MAX)) gain_d = gain_q + GW'(1);
            if (gain_d == GAIN_MAX) state_d = ST_ON;
        end else if (state_d == ST_RAMP_DOWN) begin
            if (tick_i && (gain_q != '0)) gain_d = gain_q - GW'(1);
            if (gain_d == '0) state_d = ST_OFF;
        end
    end

    // Gain is zero-extended so it multiplies as a non-negative signed value;
    // the arithmetic shift floors, and unity gain reproduces sat_i exactly.
    always_comb begin
        prod   = sat_i * $signed({1'b0, gain_q});
        data_d = OUTPUT_WIDTH'(prod >>> FADE_BITS);
    end

    assign data_o    = data_q;
    assign active_o  = (state_q != ST_OFF);
    assign ramping_o = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);

endmodule : fade_gate_channel

// File: rtl/conditional_splitter_1x8.sv
// ---------------------------------------------------------------------------
// conditional_splitter_1x8
// Distributes one summed feedback word to 8 channels. Each channel fades its
// gain linearly between 0 and unity when its select bit changes, so enabling
// or disabling a channel never steps the output.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   enable_select_i[7:0] : per-channel on request
//   data_i               : signed input sample (INPUT_WIDTH)
//   data0_o..data7_o     : signed faded outputs (OUTPUT_WIDTH)
//   active_o[7:0]        : channel k not OFF
//   busy_o               : any channel ramping
// Optional (macro CONDITIONAL_SPLITTER_SAT_FLAG_EN):
//   sat_clear_i          : clears the sticky saturation flag
//   sat_flag_o           : sticky flag, set whenever the input clamps
// ---------------------------------------------------------------------------
module conditional_splitter_1x8
    import pt_feedback_pkg::*;
#(
    parameter int INPUT_WIDTH   = 17,
    parameter int OUTPUT_WIDTH  = 14,
    parameter int FADE_BITS     = 8,
    parameter int FADE_STEP_DIV = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_CH-1:0]                enable_select_i,
    input  logic signed [INPUT_WIDTH-1:0]  data_i,
    output logic signed [OUTPUT_WIDTH-1:0] data0_o,
    output logic signed [OUTPUT_WIDTH-1:0] data1_o,
    output logic signed [OUTPUT_WIDTH-1:0] data2_o,
    output logic signed [OUTPUT_WIDTH-1:0] data3_o,
    output logic signed [OUTPUT_WIDTH-1:0] data4_o,
    output logic signed [OUTPUT_WIDTH-1:0] data5_o,
    output logic signed [OUTPUT_WIDTH-1:0] data6_o,
    output logic signed [OUTPUT_WIDTH-1:0] data7_o,
    output logic [N_CH-1:0]                active_o,
    output logic                           busy_o
`ifdef CONDITIONAL_SPLITTER_SAT_FLAG_EN
    ,
    input  logic                           sat_clear_i,
    output logic                           sat_flag_o
`endif
);

    localparam int PRESC_W = (FADE_STEP_DIV > 1) ? $clog2(FADE_STEP_DIV) : 1;

    logic [PRESC_W-1:0]             presc_q, presc_d;
    logic                           tick;
    logic signed [OUTPUT_WIDTH-1:0] sat_q, sat_d;
    logic                           clamp_hi, clamp_lo;
    logic signed [OUTPUT_WIDTH-1:0] data_ch [N_CH];
    logic [N_CH-1:0]                ramping;

    // Free-running step prescaler; with a divider of 1 the count stays 0 and
    // tick is asserted every cycle.
    assign tick    = (presc_q == PRESC_W'(FADE_STEP_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + PRESC_W'(1);

    generate
        if (INPUT_WIDTH > OUTPUT_WIDTH) begin : g_sat
            localparam logic signed [INPUT_WIDTH-1:0] SAT_MAX =
                INPUT_WIDTH'((2 ** (OUTPUT_WIDTH - 1)) - 1);
            localparam logic signed [INPUT_WIDTH-1:0] SAT_MIN =
                INPUT_WIDTH'(-(2 ** (OUTPUT_WIDTH - 1)));
            assign clamp_hi = (data_i > SAT_MAX);
            assign clamp_lo = (data_i < SAT_MIN);
            assign sat_d    = clamp_hi ? {1'b0, {(OUTPUT_WIDTH-1){1'b1}}} :
                              clamp_lo ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}} :
                                         data_i[OUTPUT_WIDTH-1:0];
        end else begin : g_nosat
            // Input already fits the output range: sign-extend only.
            assign clamp_hi = 1'b0;
            assign clamp_lo = 1'b0;
            assign sat_d    = OUTPUT_WIDTH'(data_i);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            sat_q   <= '0;
        end else begin
            presc_q <= presc_d;
            sat_q   <= sat_d;
        end
    end

`ifdef CONDITIONAL_SPLITTER_SAT_FLAG_EN
    logic sat_flag_q;

    // A clamp wins over a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_flag_q <= 1'b0;
        end else if (clamp_hi || clamp_lo) begin
            sat_flag_q <= 1'b1;
        end else if (sat_clear_i) begin
            sat_flag_q <= 1'b0;
        end
    end

    assign sat_flag_o = sat_flag_q;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            fade_gate_channel #(
                .OUTPUT_WIDTH (OUTPUT_WIDTH),
                .FADE_BITS    (FADE_BITS)
            ) u_ch (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .sat_i     (sat_q),
                .sel_i     (enable_select_i[gi]),
                .tick_i    (tick),
                .data_o    (data_ch[gi]),
                .active_o  (active_o[gi]),
                .ramping_o (ramping[gi])
            );
        end
    endgenerate

    assign busy_o  = |ramping;
    assign data0_o = data_ch[0];
    assign data1_o = data_ch[1];
    assign data2_o = data_ch[2];
    assign data3_o = data_ch[3];
    assign data4_o = data_ch[4];
    assign data5_o = data_ch[5];
    assign data6_o = data_ch[6];
    assign data7_o = data_ch[7];

endmodule : conditional_splitter_1x8

// File: tb/tb_conditional_splitter_1x8.sv
// ---------------------------------------------------------------------------
// tb_conditional_splitter_1x8
// Directed bench: one instance at default parameters and one fast instance
// (FADE_BITS=2, FADE_STEP_DIV=1). Inputs change and outputs are sampled on
// the falling clock edge.
// ---------------------------------------------------------------------------
module tb_conditional_splitter_1x8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic               rst_n;
    logic [7:0]         sel;
    logic signed [16:0] din;
    logic signed [13:0] d [8];
    logic [7:0]         act;
    logic               busy;

    // fast instance
    logic               rst_f_n;
    logic [7:0]         sel_f;
    logic signed [16:0] din_f;
    logic signed [13:0] df [8];
    logic [7:0]         act_f;
    logic               busy_f;

`ifdef CONDITIONAL_SPLITTER_SAT_FLAG_EN
    logic sat_clear, sat_flag, sat_clear_f, sat_flag_f;
`endif

    conditional_splitter_1x8 dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_select_i(sel), .data_i(din),
        .data0_o(d[0]), .data1_o(d[1]), .data2_o(d[2]), .data3_o(d[3]),
        .data4_o(d[4]), .data5_o(d[5]), .data6_o(d[6]), .data7_o(d[7]),
        .active_o(act), .busy_o(busy)
`ifdef CONDITIONAL_SPLITTER_SAT_FLAG_EN
        , .sat_clear_i(sat_clear), .sat_flag_o(sat_flag)
`endif
    );

    conditional_splitter_1x8 #(.FADE_BITS(2), .FADE_STEP_DIV(1)) dut_f (
        .clk_i(clk), .rst_ni(rst_f_n), .enable_select_i(sel_f), .data_i(din_f),
        .data0_o(df[0]), .data1_o(df[1]), .data2_o(df[2]), .data3_o(df[3]),
        .data4_o(df[4]), .data5_o(df[5]), .data6_o(df[6]), .data7_o(df[7]),
        .active_o(act_f), .busy_o(busy_f)
`ifdef CONDITIONAL_SPLITTER_SAT_FLAG_EN
        , .sat_clear_i(sat_clear_f), .sat_flag_o(sat_flag_f)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint actual, input longint expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, actual, expected);
        end
    endtask

    typedef struct {
        logic signed [16:0] din;
        logic signed [13:0] dout;
    } vec_t;

    vec_t vecs [10];

    // Pulse the default instance reset and release it with new inputs.
    task automatic restart(input logic [7:0] s, input logic signed [16:0] x);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        sel   = s;
        din   = x;
        rst_n = 1'b1;
    endtask

    initial begin
        int  peak;
        int  prev;
        bit  mono_ok;
        bit  step_ok;
        int  fast_exp [5];

        vecs[0] = '{din: 17'sd20000,  dout: 14'sd8191};
        vecs[1] = '{din: -17'sd20000, dout: -14'sd8192};
        vecs[2] = '{din: -17'sd5,     dout: -14'sd5};
        vecs[3] = '{din: 17'sd8191,   dout: 14'sd8191};
        vecs[4] = '{din: 17'sd8192,   dout: 14'sd8191};
        vecs[5] = '{din: -17'sd8192,  dout: -14'sd8192};
        vecs[6] = '{din: -17'sd8193,  dout: -14'sd8192};
        vecs[7] = '{din: 17'sd0,      dout: 14'sd0};
        vecs[8] = '{din: 17'sd65535,  dout: 14'sd8191};
        vecs[9] = '{din: -17'sd65536, dout: -14'sd8192};

        fast_exp = '{0, 1000, 2000, 3000, 4000};

        rst_n   = 1'b0;
        sel     = 8'hFF;
        din     = 17'sd1000;
        rst_f_n = 1'b0;
        sel_f   = 8'h01;
        din_f   = 17'sd4000;
`ifdef CONDITIONAL_SPLITTER_SAT_FLAG_EN
        sat_clear   = 1'b0;
        sat_clear_f = 1'b0;
`endif

        // ---- reset held: outputs stay 0 ----
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_d0", d[0], 0);
            chk("rst_d7", d[7], 0);
            chk("rst_active", act, 0);
            chk("rst_busy", busy, 0);
        end

        // ---- fast instance: ramp with tick every cycle, then 2-cycle latency ----
        rst_f_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            $display("fast ramp cycle %0d: df0=%0d", c + 1, df[0]);
            chk("fast_ramp", df[0], fast_exp[c]);
        end
        chk("fast_busy_done", busy_f, 0);
        din_f = 17'sd0;
        repeat (3) @(negedge clk);
        chk("fast_zero", df[0], 0);
        din_f = 17'sd4000;
        @(negedge clk);
        chk("fast_lat1", df[0], 0);
        @(negedge clk);
        chk("fast_lat2", df[0], 4000);

        // ---- test 1: full ramp from reset at defaults ----
        rst_n   = 1'b1;
        prev    = 0;
        mono_ok = 1'b1;
        for (int c = 1; c <= 4100; c++) begin
            @(negedge clk);
            if (d[0] < prev) mono_ok = 1'b0;
            prev = d[0];
            if (c == 2000) chk("ramp_mid_d0", d[0], 484);
            if (c == 4095) chk("ramp_busy", busy, 1);
            if (c == 4096) chk("ramp_pre_unity", d[0], 996);
            if (c == 4098) chk("ramp_unity", d[0], 1000);
            if (c == 4098) chk("ramp_busy_drop", busy, 0);
        end
        chk("ramp_monotonic", mono_ok, 1);
        chk("ramp_active", act, 8'hFF);

        // ---- test 2: saturation table at unity gain ----
        for (int i = 0; i < 10; i++) begin
            din = vecs[i].din;
            repeat (2) @(negedge clk);
            $display("sat vec %0d: in=%0d d0=%0d d5=%0d", i, vecs[i].din, d[0], d[5]);
            chk("sat_d0", d[0], vecs[i].dout);
            chk("sat_d5", d[5], vecs[i].dout);
        end

        // ---- test 4: ramp abort after 100 ticks (output = 16*gain) ----
        restart(8'h01, 17'sd4096);
        peak    = 0;
        prev    = 0;
        step_ok = 1'b1;
        for (int c = 1; c <= 3210; c++) begin
            @(negedge clk);
            if (c == 1600) sel = 8'h00;
            if (d[0] > peak) peak = d[0];
            if ((d[0] - prev > 17) || (prev - d[0] > 17)) step_ok = 1'b0;
            prev = d[0];
            if (c == 1601) chk("abort_peak_out", d[0], 1600);
            if (c == 1617) chk("abort_first_down", d[0], 1584);
            if (c == 2400) chk("abort_other_ch", d[1], 0);
            if (c == 3199) chk("abort_active_hold", act[0], 1);
            if (c == 3200) chk("abort_active_fall", act[0], 0);
            if (c == 3201) chk("abort_zero", d[0], 0);
        end
        chk("abort_peak", peak, 1600);
        chk("abort_step", step_ok, 1);

        // ---- test 6: asynchronous reset mid-ramp at gain 50 ----
        restart(8'h01, 17'sd4096);
        repeat (805) @(negedge clk);
        chk("mid_out", d[0], 800);
        #2 rst_n = 1'b0;
        #1;
        chk("async_d0", d[0], 0);
        chk("async_active", act, 0);
        chk("async_busy", busy, 0);

        // ---- test 5: two channels ramp to -3000 ----
        @(negedge clk);
        sel   = 8'h81;
        din   = -17'sd3000;
        rst_n = 1'b1;
        for (int c = 1; c <= 4100; c++) begin
            @(negedge clk);
            if (c == 10) chk("two_active", act, 8'h81);
            if (c == 10) chk("two_busy", busy, 1);
            if (c == 2000) chk("two_mid_d0", d[0], -1454);
            if (c == 2000) chk("two_mid_d3", d[3], 0);
        end
        chk("two_d0", d[0], -3000);
        chk("two_d7", d[7], -3000);
        for (int k = 1; k < 7; k++) chk("two_off", d[k], 0);
        chk("two_active_end", act, 8'h81);

`ifdef CONDITIONAL_SPLITTER_SAT_FLAG_EN
        // ---- saturation flag: clear, set, clear, set-with-clear ----
        din       = 17'sd0;
        sat_clear = 1'b1;
        @(negedge clk);
        sat_clear = 1'b0;
        chk("flag_cleared", sat_flag, 0);
        din = 17'sd20000;
        @(negedge clk);
        chk("flag_set", sat_flag, 1);
        din       = 17'sd0;
        sat_clear = 1'b1;
        @(negedge clk);
        chk("flag_clear", sat_flag, 0);
        din = -17'sd9000;
        @(negedge clk);
        chk("flag_set_wins", sat_flag, 1);
        sat_clear = 1'b0;
        din       = 17'sd0;
        @(negedge clk);
        chk("flag_sticky", sat_flag, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_conditional_splitter_1x8
